// File: rtl/cache_pkg.sv
// Shared cache definitions: controller state encoding, line/word geometry,
// and word select/merge helpers used on the data path.
package cache_pkg;

  localparam int WAY_NUM       = 4;
  localparam int LINE_WIDTH    = 128;
  localparam int WORD_WIDTH    = 32;
  localparam int WORD_IDX_LSB  = 2;
  localparam int WORD_IDX_W    = 2;
  localparam int LINE_OFFSET_W = 4;

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [WORD_IDX_W-1:0] word_idx_t;
  typedef logic [WAY_NUM-1:0]    way_oh_t;
  typedef logic [1:0]            way_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WB     = 3'd2,
    ST_MREQ   = 3'd3,
    ST_MWAIT  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic word_t word_sel(input line_t line, input word_idx_t idx);
    return line[int'(idx)*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  function automatic line_t word_merge(input line_t line, input word_idx_t idx, input word_t w);
    line_t r;
    r = line;
    r[int'(idx)*WORD_WIDTH +: WORD_WIDTH] = w;
    return r;
  endfunction

  function automatic way_oh_t way_onehot(input way_idx_t way);
    way_oh_t r;
    r      = '0;
    r[way] = 1'b1;
    return r;
  endfunction

  // Isolates the lowest set bit so a multi-hot lookup still writes a single way.
  function automatic way_oh_t lowest_set(input way_oh_t v);
    return v & (~v + way_oh_t'(1));
  endfunction

endpackage

// File: rtl/cache_miss_ctrl.sv
// Single-outstanding cache miss controller: hit service, dirty victim
// write-back, line refill from memory, and word merge for stores.
//
// state  | meaning
// IDLE   | ready for a new CPU request
// LOOKUP | tag result valid; hit served here, miss info captured
// WB     | pushing dirty victim line to the write buffer
// MREQ   | issuing the line read to memory
// MWAIT  | waiting for the single-beat refill
// RESP   | one-cycle completion pulse to the CPU
module cache_miss_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = cache_pkg::LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            lk_hit,
  input  logic [1:0]            lk_victim,
  input  logic                  lk_dirty,
  input  logic [ADDR_WIDTH-1:0] lk_victim_addr,
  input  logic [LINE_WIDTH-1:0] lk_line,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [LINE_WIDTH-1:0] wb_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data,
  output logic [3:0]            line_we,
  output logic [LINE_WIDTH-1:0] line_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata
);

  import cache_pkg::*;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  word_t                 wdata_q, wdata_d;
  way_idx_t              victim_q, victim_d;
  logic [ADDR_WIDTH-1:0] victim_addr_q, victim_addr_d;
  line_t                 victim_line_q, victim_line_d;
  word_t                 rdata_q, rdata_d;

  word_idx_t widx;
  logic      lk_any_hit;
  way_oh_t   hit_way;

  assign widx       = addr_q[WORD_IDX_LSB +: WORD_IDX_W];
  assign lk_any_hit = |lk_hit;
  assign hit_way    = lowest_set(lk_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      victim_q      <= '0;
      victim_addr_q <= '0;
      victim_line_q <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      victim_q      <= victim_d;
      victim_addr_q <= victim_addr_d;
      victim_line_q <= victim_line_d;
      rdata_q       <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (lk_any_hit)    state_d = ST_RESP;
        else if (lk_dirty) state_d = ST_WB;
        else               state_d = ST_MREQ;
      end
      ST_WB:     if (wb_ready)       state_d = ST_MREQ;
      ST_MREQ:   if (mem_req_ready)  state_d = ST_MWAIT;
      ST_MWAIT:  if (mem_resp_valid) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch, miss capture and load-word capture.
  always_comb begin
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    victim_d      = victim_q;
    victim_addr_d = victim_addr_q;
    victim_line_d = victim_line_q;
    rdata_d       = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_LOOKUP: begin
        if (lk_any_hit) begin
          rdata_d = wr_q ? '0 : word_sel(lk_line, widx);
        end else begin
          victim_d      = lk_victim;
          victim_addr_d = lk_victim_addr;
          victim_line_d = lk_line;
        end
      end
      ST_MWAIT: begin
        if (mem_resp_valid) rdata_d = wr_q ? '0 : word_sel(mem_resp_data, widx);
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    wb_valid      = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    line_we       = '0;
    line_wdata    = '0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_LOOKUP: begin
        if (lk_any_hit && wr_q) begin
          line_we    = hit_way;
          line_wdata = word_merge(lk_line, widx, wdata_q);
        end
      end
      ST_WB: begin
        wb_valid = 1'b1;
        wb_addr  = victim_addr_q;
        wb_data  = victim_line_q;
      end
      ST_MREQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDR_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
      end
      ST_MWAIT: begin
        if (mem_resp_valid) begin
          line_we    = way_onehot(victim_q);
          line_wdata = wr_q ? word_merge(mem_resp_data, widx, wdata_q) : mem_resp_data;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: table of hit vectors plus hand-written
// miss, write-back and mid-refill reset sequences.
module tb_cache_miss_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   lk_hit;
  logic [1:0]   lk_victim;
  logic         lk_dirty;
  logic [31:0]  lk_victim_addr;
  logic [127:0] lk_line;
  logic         wb_valid;
  logic         wb_ready;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [3:0]   line_we;
  logic [127:0] line_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  cache_miss_ctrl #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .lk_hit         (lk_hit),
    .lk_victim      (lk_victim),
    .lk_dirty       (lk_dirty),
    .lk_victim_addr (lk_victim_addr),
    .lk_line        (lk_line),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .line_we        (line_we),
    .line_wdata     (line_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   hit;
    logic [127:0] line;
    logic [3:0]   exp_we;
    logic [127:0] exp_wdata;
    logic [31:0]  exp_rdata;
  } hit_vec_t;

  hit_vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_lk;
    lk_hit         = '0;
    lk_victim      = '0;
    lk_dirty       = 1'b0;
    lk_victim_addr = '0;
    lk_line        = '0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    chk("issue_req_ready", {127'b0, req_ready}, 128'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    step;
    // Scramble the request bus: the controller must work from its latched copy.
    req_valid = 1'b0;
    req_wr    = ~wr;
    req_addr  = 32'hFFFF_0000;
    req_wdata = 32'h0;
  endtask

  task automatic run_hit(input int i);
    hit_vec_t v;
    v = vecs[i];
    issue(v.wr, v.addr, v.wdata);
    lk_hit   = v.hit;
    lk_line  = v.line;
    lk_dirty = 1'b1;
    settle;
    chk($sformatf("hit%0d_lookup_ready", i), {127'b0, req_ready}, 128'd0);
    chk($sformatf("hit%0d_line_we", i), {124'b0, line_we}, {124'b0, v.exp_we});
    chk($sformatf("hit%0d_line_wdata", i), line_wdata, v.exp_wdata);
    chk($sformatf("hit%0d_early_resp", i), {127'b0, resp_valid}, 128'd0);
    chk($sformatf("hit%0d_no_wb_mreq", i), {126'b0, wb_valid, mem_req_valid}, 128'd0);
    step;
    clear_lk;
    settle;
    chk($sformatf("hit%0d_resp_valid", i), {127'b0, resp_valid}, 128'd1);
    chk($sformatf("hit%0d_resp_rdata", i), {96'b0, resp_rdata}, {96'b0, v.exp_rdata});
    chk($sformatf("hit%0d_resp_we", i), {124'b0, line_we}, 128'd0);
    step;
    settle;
    chk($sformatf("hit%0d_back_idle", i), {126'b0, req_ready, resp_valid}, 128'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0008, 32'h0, 4'b0100,
                128'h44444444_DEADBEEF_22222222_11111111,
                4'b0000, 128'h0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'b0001,
                128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
                4'b0001, 128'hAAAAAAAA_BBBBBBBB_12345678_DDDDDDDD, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_010F, 32'h0, 4'b1000,
                128'h01020304_05060708_090A0B0C_0D0E0F10,
                4'b0000, 128'h0, 32'h0102_0304};
    vecs[3] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'b0110,
                128'h11112222_33334444_55556666_77778888,
                4'b0010, 128'h11112222_33334444_55556666_CAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h0, 4'b1010,
                128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0001,
                4'b0000, 128'h0, 32'hDDDD_EEEE};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'b1000,
                128'h0,
                4'b1000, 128'hA5A5A5A5_00000000_00000000_00000000, 32'h0};

    rst            = 1'b1;
    req_valid      = 1'b0;
    req_wr         = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    wb_ready       = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    clear_lk;
    step;
    step;
    rst = 1'b0;
    settle;
    chk("reset_req_ready", {127'b0, req_ready}, 128'd1);
    chk("reset_outputs", {124'b0, wb_valid, mem_req_valid, resp_valid, |line_we}, 128'd0);
    chk("reset_buses", {wb_addr, mem_req_addr, resp_rdata, 32'b0} | wb_data | line_wdata, 128'd0);

    for (int i = 0; i < 6; i++) run_hit(i);

    // Clean load miss, victim way 3, memory slow to accept.
    issue(1'b0, 32'h0000_1238, 32'h0);
    lk_victim      = 2'd3;
    lk_victim_addr = 32'h0000_5550;
    lk_line        = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    settle;
    chk("cmiss_lookup", {124'b0, wb_valid, mem_req_valid, resp_valid, |line_we}, 128'd0);
    step;
    clear_lk;
    for (int k = 0; k < 4; k++) begin
      mem_req_ready = (k == 3);
      settle;
      chk($sformatf("cmiss_mreq_valid%0d", k), {126'b0, mem_req_valid, wb_valid}, 128'd2);
      chk($sformatf("cmiss_mreq_addr%0d", k), {96'b0, mem_req_addr}, 128'h1230);
      step;
    end
    mem_req_ready = 1'b0;
    settle;
    chk("cmiss_mwait_idle", {124'b0, mem_req_valid, wb_valid, resp_valid, |line_we}, 128'd0);
    step;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'h44444444_FEEDFACE_22222222_11111111;
    settle;
    chk("cmiss_refill_we", {124'b0, line_we}, 128'b1000);
    chk("cmiss_refill_data", line_wdata, 128'h44444444_FEEDFACE_22222222_11111111);
    chk("cmiss_refill_excl", {126'b0, wb_valid, mem_req_valid}, 128'd0);
    step;
    settle;
    chk("cmiss_resp_we_stray", {124'b0, line_we}, 128'd0);
    mem_resp_valid = 1'b0;
    chk("cmiss_resp_valid", {127'b0, resp_valid}, 128'd1);
    chk("cmiss_resp_rdata", {96'b0, resp_rdata}, 128'hFEEDFACE);
    step;

    // Dirty store miss, write buffer stalls for four cycles.
    issue(1'b1, 32'h0000_2004, 32'h0BAD_C0DE);
    lk_dirty       = 1'b1;
    lk_victim      = 2'd1;
    lk_victim_addr = 32'h0000_7770;
    lk_line        = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
    settle;
    chk("dmiss_lookup_we", {124'b0, line_we}, 128'd0);
    step;
    lk_victim      = 2'd2;
    lk_victim_addr = 32'hBAD0_BAD0;
    lk_line        = '1;
    for (int k = 0; k < 5; k++) begin
      wb_ready = (k == 4);
      settle;
      chk($sformatf("dmiss_wb_valid%0d", k), {126'b0, wb_valid, mem_req_valid}, 128'd2);
      chk($sformatf("dmiss_wb_addr%0d", k), {96'b0, wb_addr}, 128'h7770);
      chk($sformatf("dmiss_wb_data%0d", k), wb_data, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C);
      step;
    end
    wb_ready = 1'b0;
    clear_lk;
    mem_req_ready = 1'b1;
    settle;
    chk("dmiss_mreq", {126'b0, mem_req_valid, wb_valid}, 128'd2);
    chk("dmiss_mreq_addr", {96'b0, mem_req_addr}, 128'h2000);
    step;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'h11111111_22222222_33333333_44444444;
    settle;
    chk("dmiss_refill_we", {124'b0, line_we}, 128'b0010);
    chk("dmiss_refill_data", line_wdata, 128'h11111111_22222222_0BADC0DE_44444444);
    step;
    mem_resp_valid = 1'b0;
    settle;
    chk("dmiss_resp", {127'b0, resp_valid}, 128'd1);
    chk("dmiss_resp_rdata", {96'b0, resp_rdata}, 128'd0);
    step;

    // Reset while waiting for refill; a late refill beat must be dropped.
    issue(1'b0, 32'h0000_0040, 32'h0);
    lk_victim = 2'd0;
    step;
    clear_lk;
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    settle;
    chk("rst_in_mwait", {126'b0, req_ready, mem_req_valid}, 128'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    settle;
    chk("rst_req_ready", {127'b0, req_ready}, 128'd1);
    chk("rst_outputs", {124'b0, wb_valid, mem_req_valid, resp_valid, |line_we}, 128'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    settle;
    chk("rst_stray_we", {124'b0, line_we}, 128'd0);
    step;
    mem_resp_valid = 1'b0;
    settle;
    chk("rst_stray_after", {126'b0, req_ready, resp_valid}, 128'd2);
    run_hit(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, meaning cacheline width: 4 words of 32 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, CPU load/store request.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_wr, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, byte address; addr[3:2] is the word index, addr[1:0] is ignored.
REQ-009 SHALL have port req_wdata, input, 32, store word.
REQ-010 SHALL have port lk_hit, input, 4, one-hot hit way for the latched address, valid in LOOKUP.
REQ-011 SHALL have port lk_victim, input, 2, LRU victim way index, valid in LOOKUP.
REQ-012 SHALL have port lk_dirty, input, 1, victim line dirty, valid in LOOKUP.
REQ-013 SHALL have port lk_victim_addr, input, ADDR_WIDTH, line-aligned address of the victim line.
REQ-014 SHALL have port lk_line, input, LINE_WIDTH, line data of the hit way on a hit, or of the victim way on a miss.
REQ-015 SHALL have port wb_valid, output, 1, write-buffer push request.
REQ-016 SHALL have port wb_ready, input, 1, write buffer accepts the push.
REQ-017 SHALL have port wb_addr, output, ADDR_WIDTH, victim line address.
REQ-018 SHALL have port wb_data, output, LINE_WIDTH, victim line data.
REQ-019 SHALL have port mem_req_valid, output, 1, main-memory line read request.
REQ-020 SHALL have port mem_req_ready, input, 1, memory accepts the request.
REQ-021 SHALL have port mem_req_addr, output, ADDR_WIDTH, line-aligned as {req_addr[ADDR_WIDTH-1:4], 4'b0}.
REQ-022 SHALL have port mem_resp_valid, input, 1, refill data valid (single beat).
REQ-023 SHALL have port mem_resp_data, input, LINE_WIDTH, refill line.
REQ-024 SHALL have port line_we, output, 4, one-hot data-RAM way write enable, for 1 cycle.
REQ-025 SHALL have port line_wdata, output, LINE_WIDTH, full line to write at the latched index.
REQ-026 SHALL have port resp_valid, output, 1, 1-cycle completion pulse.
REQ-027 SHALL have port resp_rdata, output, 32, load word; 0 for stores.

Function
REQ-028 SHALL implement states IDLE, LOOKUP, WB, MREQ, MWAIT, RESP; req_ready is 1 only in IDLE.
REQ-029 SHALL, on acceptance, latch req_wr/addr/wdata, go IDLE->LOOKUP, and ignore req_* until back in IDLE.
REQ-030 SHALL, in LOOKUP with hit (lowest set lk_hit bit wins if multi-hot): for a load, capture word addr[3:2] of lk_line; for a store, pulse line_we=lk_hit way with line_wdata = lk_line with word addr[3:2] replaced by wdata; then go to RESP. Hit latency: resp_valid 2 cycles after acceptance.
REQ-031 SHALL, in LOOKUP with a miss, register lk_victim, lk_victim_addr and lk_line; go to WB if lk_dirty, else MREQ.
REQ-032 SHALL, in WB, hold wb_valid=1 and stable wb_addr/wb_data until wb_ready; on wb_ready go to MREQ. Same-cycle ready gives a 1-cycle WB.
REQ-033 SHALL, in MREQ, hold mem_req_valid=1 and stable mem_req_addr until mem_req_ready, then go to MWAIT.
REQ-034 SHALL, in MWAIT, on mem_resp_valid pulse line_we=onehot(victim) with line_wdata = mem_resp_data (store: word addr[3:2] merged with wdata), capture the load word from mem_resp_data, and go to RESP.
REQ-035 SHALL ignore mem_resp_valid outside MWAIT and wb_ready/mem_req_ready outside WB/MREQ.
REQ-036 SHALL, in RESP, pulse resp_valid=1 with resp_rdata, then return to IDLE; a new request is accepted the following cycle.
REQ-037 SHALL never assert wb_valid, mem_req_valid and line_we in the same cycle; at most one line_we bit is set.

Reset
REQ-038 SHALL, on rst=1 at a clock edge (including mid-operation), go to IDLE with req_ready=1 and all other outputs 0; in-flight handshakes are dropped and no line_we is issued.

Structure
REQ-039 SHALL take the state encoding, the word-index constants, WAY_NUM=4 and LINE_WIDTH from the shared cache package cache_pkg, with word select/merge as package functions; no sub-module is needed.

Verification
REQ-040 SHALL cover load hit: lk_hit=4'b0100, lk_line word2=32'hDEAD_BEEF, addr=0x08 -> resp_valid at T+2, rdata=DEADBEEF, line_we=0.
REQ-041 SHALL cover store hit: addr=0x04, wdata=0x1234_5678, lk_hit=4'b0001 -> line_we=4'b0001 in LOOKUP, bits[63:32]=12345678, other words unchanged.
REQ-042 SHALL cover clean load miss: lk_dirty=0, lk_victim=3, mem_req_ready delayed 3 cycles, resp after 2 more -> no wb_valid, mem_req_addr=0x0000_1230 for addr 0x1238, line_we=4'b1000, rdata=word2.
REQ-043 SHALL cover dirty store miss: lk_dirty=1, wb_ready low 4 cycles -> wb_valid held stable 5 cycles, then MREQ; refill line merged with wdata at addr[3:2].
REQ-044 SHALL cover reset mid-MWAIT: rst=1 for 1 cycle -> next cycle IDLE, req_ready=1; a later stray mem_resp_valid causes no line_we.
